// File: rtl/decoder_wr_burst_pkg.sv
// Shared types and elaboration helpers for the burst write-strobe decoder.
// The FSM state encoding is fixed because the register bank debug view decodes it.
package decoder_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  // True when a one-hot vector of depth outputs is addressable with addr_w bits.
  function automatic bit onehot_fits(input int addr_w, input int depth);
    return (depth >= 1) && (depth <= (1 << addr_w));
  endfunction

endpackage

// File: rtl/decoder_wr_burst_if.sv
// Command handshake and write-strobe bus between the command front-end and the decoder.
interface decoder_wr_burst_if #(
  parameter int ADDR_W = 3,
  parameter int DEPTH  = 6,
  parameter int LEN_W  = 4
);

  logic              i_valid;
  logic              o_ready;
  logic [ADDR_W-1:0] i_addr;
  logic [LEN_W-1:0]  i_len;
  logic              i_we;
  logic              i_clr;
  logic [DEPTH-1:0]  o_decoder;
  logic              o_busy;
  logic              o_done;
  logic              o_err;

  modport master (
    output i_valid, i_addr, i_len, i_we, i_clr,
    input  o_ready, o_decoder, o_busy, o_done, o_err
  );

  modport slave (
    input  i_valid, i_addr, i_len, i_we, i_clr,
    output o_ready, o_decoder, o_busy, o_done, o_err
  );

endinterface

// File: rtl/decoder_wr_burst_onehot.sv
// Combinational enable-gated address to one-hot decoder; out-of-range addresses give all zeros.
// Also used on the register bank read path, so it carries no state.
module decoder_onehot #(
  parameter int ADDR_W = 3,
  parameter int DEPTH  = 6
) (
  input  logic              i_en,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DEPTH-1:0]  o_onehot
);

  // Only indices below DEPTH exist, so an address >= DEPTH matches no bit.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_bit
    assign o_onehot[gi] = i_en && (i_addr == ADDR_W'(gi));
  end

endmodule

// File: rtl/decoder_wr_burst.sv
// Burst write-strobe decoder: accepts a start/length command and emits one registered
// one-hot strobe per cycle over consecutive bank entries, wrapping at DEPTH.
module decoder_wr_burst
  import decoder_pkg::*;
#(
  parameter int ADDR_W = 3,
  parameter int DEPTH  = 6,
  parameter int LEN_W  = 4
) (
  input  logic               i_clk,
  input  logic               i_rst,
  decoder_wr_burst_if.slave  bus
);

  if (!onehot_fits(ADDR_W, DEPTH)) begin : g_bad_cfg
    $error("decoder_wr_burst: DEPTH must satisfy 1 <= DEPTH <= 2**ADDR_W");
  end

  localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t            r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [LEN_W-1:0]  r_count;
  logic              r_we;
  logic [DEPTH-1:0]  r_decoder;
  logic              r_busy;
  logic              r_done;
  logic              r_err;

  logic              w_last_beat;
  logic              w_ready;
  logic              w_accept;
  logic              w_in_range;
  logic [ADDR_W-1:0] w_next_addr;
  logic [ADDR_W-1:0] w_dec_addr;
  logic              w_dec_en;
  logic [DEPTH-1:0]  w_onehot;

  // An abort in the last beat blocks acceptance so the bank never sees a command race the clear.
  assign w_last_beat = (r_state == BURST) && (r_count == '0) && !bus.i_clr;
  assign w_ready     = (r_state == IDLE) || w_last_beat;
  assign w_accept    = bus.i_valid && w_ready;
  assign w_in_range  = {1'b0, bus.i_addr} < DEPTH_EXT;
  assign w_next_addr = (r_addr == LAST_ADDR) ? '0 : r_addr + 1'b1;

  // The strobe register is loaded from the address it will present, so both the
  // first beat (from the command) and later beats (from the stepped address) share one decoder.
  assign w_dec_addr = w_accept ? bus.i_addr : w_next_addr;
  assign w_dec_en   = w_accept ? bus.i_we : r_we;

  decoder_onehot #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_onehot (
    .i_en     (w_dec_en),
    .i_addr   (w_dec_addr),
    .o_onehot (w_onehot)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state   <= IDLE;
      r_addr    <= '0;
      r_count   <= '0;
      r_we      <= 1'b0;
      r_decoder <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      if (w_accept) begin
        if (w_in_range) begin
          r_state   <= BURST;
          r_addr    <= bus.i_addr;
          r_count   <= bus.i_len;
          r_we      <= bus.i_we;
          r_decoder <= w_onehot;
          r_busy    <= 1'b1;
          r_done    <= (bus.i_len == '0);
        end else begin
          r_state   <= IDLE;
          r_decoder <= '0;
          r_busy    <= 1'b0;
          r_err     <= 1'b1;
        end
      end else if (r_state == BURST) begin
        if (bus.i_clr || (r_count == '0)) begin
          r_state   <= IDLE;
          r_decoder <= '0;
          r_busy    <= 1'b0;
        end else begin
          r_count   <= r_count - 1'b1;
          r_addr    <= w_next_addr;
          r_decoder <= w_onehot;
          r_done    <= (r_count == LEN_W'(1));
        end
      end
    end
  end

  assign bus.o_ready   = w_ready;
  assign bus.o_decoder = r_decoder;
  assign bus.o_busy    = r_busy;
  assign bus.o_done    = r_done;
  assign bus.o_err     = r_err;

endmodule

// File: tb/tb_decoder_wr_burst.sv
// Scoreboard bench for decoder_wr_burst: commands expand into expected beat lists,
// a negedge monitor pops and compares every presented beat.
module tb_decoder_wr_burst;

  localparam int ADDR_W = 3;
  localparam int DEPTH  = 6;
  localparam int LEN_W  = 4;

  typedef struct packed {
    logic [DEPTH-1:0] dec;
    logic             done;
    logic             err;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int checks = 0;
  int errors = 0;

  exp_t exp_q[$];

  logic              pend_valid = 1'b0;
  logic [ADDR_W-1:0] pend_addr;
  logic [LEN_W-1:0]  pend_len;
  logic              pend_we;

  decoder_wr_burst_if #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .LEN_W(LEN_W)) bus ();

  decoder_wr_burst #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .LEN_W(LEN_W)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Expand a command into its beats straight from the burst rules.
  task automatic push_cmd(input logic [ADDR_W-1:0] a, input logic [LEN_W-1:0] l, input logic w);
    exp_t e;
    if (int'(a) >= DEPTH) begin
      e.dec = '0; e.done = 1'b0; e.err = 1'b1;
      exp_q.push_back(e);
    end else begin
      for (int k = 0; k <= int'(l); k++) begin
        e.dec  = w ? (DEPTH'(1) << ((int'(a) + k) % DEPTH)) : '0;
        e.done = (k == int'(l));
        e.err  = 1'b0;
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic check_outs_zero(input string name);
    checks++;
    if (bus.o_decoder !== '0 || bus.o_busy !== 1'b0 || bus.o_done !== 1'b0 || bus.o_err !== 1'b0) begin
      errors++;
      $display("FAIL %s: dec=%b busy=%b done=%b err=%b, required all zero",
               name, bus.o_decoder, bus.o_busy, bus.o_done, bus.o_err);
    end
  endtask

  // One clock of stimulus; inputs change 1 time unit after the rising edge.
  task automatic cycle(input logic v, input logic [ADDR_W-1:0] a, input logic [LEN_W-1:0] l,
                       input logic w, input logic c);
    logic exp_ready;
    @(posedge clk);
    #1;
    if (pend_valid) begin
      push_cmd(pend_addr, pend_len, pend_we);
      pend_valid = 1'b0;
    end
    bus.i_valid = v; bus.i_addr = a; bus.i_len = l; bus.i_we = w; bus.i_clr = c;
    #1;
    exp_ready = (exp_q.size() == 0) ||
                (exp_q.size() == 1 && (exp_q[0].err || (exp_q[0].done && !c)));
    checks++;
    if (bus.o_ready !== exp_ready) begin
      errors++;
      $display("FAIL ready: got %b required %b (valid=%b addr=%0d clr=%b)", bus.o_ready, exp_ready, v, a, c);
    end
    if (c && exp_q.size() > 0 && !exp_q[0].err) begin
      while (exp_q.size() > 1) void'(exp_q.pop_back());
    end
    $display("cycle t=%0t valid=%b addr=%0d len=%0d we=%b clr=%b accept=%b",
             $time, v, a, l, w, c, v && exp_ready);
    if (v && exp_ready) begin
      pend_valid = 1'b1; pend_addr = a; pend_len = l; pend_we = w;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, '0, '0, 1'b0, 1'b0);
  endtask

  // Monitor: every presented beat or error pulse must match the queue head.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (bus.o_busy || bus.o_err) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL beat: unexpected dec=%b busy=%b done=%b err=%b, required idle",
                   bus.o_decoder, bus.o_busy, bus.o_done, bus.o_err);
        end else begin
          e = exp_q.pop_front();
          if (bus.o_decoder !== e.dec || bus.o_done !== e.done || bus.o_err !== e.err ||
              bus.o_busy !== !e.err) begin
            errors++;
            $display("FAIL beat: got dec=%b done=%b err=%b busy=%b required dec=%b done=%b err=%b busy=%b",
                     bus.o_decoder, bus.o_done, bus.o_err, bus.o_busy, e.dec, e.done, e.err, !e.err);
          end
        end
      end else begin
        checks++;
        if (bus.o_decoder !== '0 || bus.o_done !== 1'b0 || exp_q.size() != 0) begin
          errors++;
          $display("FAIL idle: got dec=%b done=%b with %0d beats pending, required dec=0 done=0 none pending",
                   bus.o_decoder, bus.o_done, exp_q.size());
          if (exp_q.size() != 0) void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    bus.i_valid = 1'b0; bus.i_addr = '0; bus.i_len = '0; bus.i_we = 1'b0; bus.i_clr = 1'b0;
    #1;
    check_outs_zero("reset_outs");
    checks++;
    if (bus.o_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: got %b required 1", bus.o_ready);
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #1 check_outs_zero("post_reset_outs");

    // Single write, wrap burst, out-of-range pair
    cycle(1, 3'd2, 4'd0, 1, 0); idle(2);
    cycle(1, 3'd4, 4'd3, 1, 0); idle(5);
    cycle(1, 3'd7, 4'd0, 1, 0); idle(1);
    cycle(1, 3'd6, 4'd2, 1, 0); idle(1);
    // Back-to-back: second command offered during the last beat
    cycle(1, 3'd0, 4'd1, 1, 0); idle(1);
    cycle(1, 3'd3, 4'd0, 1, 0); idle(3);
    // Out-of-range command accepted on a last beat
    cycle(1, 3'd5, 4'd0, 1, 0); cycle(1, 3'd7, 4'd0, 1, 0); idle(2);
    // Abort on the second beat, then dry run
    cycle(1, 3'd1, 4'd4, 1, 0); idle(1);
    cycle(0, 3'd0, 4'd0, 0, 1); idle(3);
    cycle(1, 3'd1, 4'd2, 0, 0); idle(5);
    // Longest burst wraps several times
    cycle(1, 3'd5, 4'd15, 1, 0); idle(18);
    // Clear in idle has no effect on a command in the same cycle
    cycle(1, 3'd3, 4'd1, 1, 1); idle(4);

    // Reset mid-burst clears everything asynchronously
    cycle(1, 3'd0, 4'd7, 1, 0); idle(2);
    #1 rst = 1'b1;
    #1 check_outs_zero("async_reset_midburst");
    exp_q.delete();
    pend_valid = 1'b0;
    @(posedge clk); @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < 500; i++) begin
      cycle(($urandom % 3) != 0, ADDR_W'($urandom % 8), LEN_W'($urandom % 16),
            ($urandom % 4) != 0, ($urandom % 12) == 0);
    end
    idle(20);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d beats never presented, required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
